// File: rtl/bwf_pkg.sv
// Shared types and constants for the binary 3x3 window filter.
// Provides the filter mode enum, window geometry and a 3-bit popcount.
package bwf_pkg;

    typedef enum logic [1:0] {
        MAJ    = 2'd0,
        ERODE  = 2'd1,
        DILATE = 2'd2,
        PASS   = 2'd3
    } filt_mode_t;

    localparam int WIN         = 3;
    localparam int BWF_LATENCY = 3;

    function automatic logic [1:0] pop3(input logic [2:0] b);
        return {1'b0, b[0]} + {1'b0, b[1]} + {1'b0, b[2]};
    endfunction

endpackage

// File: rtl/bwf_line_buffer.sv
// Two-row line buffer for the window filter: row0 holds line v-1, row1 line v-2.
// Ports: clk, we, addr, wdata in; rdata0 (row v-1), rdata1 (row v-2) combinational out.
module bwf_line_buffer #(
    parameter int DEPTH = 320,
    parameter int W     = 1,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata0,
    output logic [W-1:0]  rdata1
);

    // Contents are never reset; the top masks stale rows via vcount.
    logic [W-1:0] row0 [DEPTH];
    logic [W-1:0] row1 [DEPTH];

    assign rdata0 = row0[addr];
    assign rdata1 = row1[addr];

    // Read-before-write: row1 takes the pre-write row0 value.
    always_ff @(posedge clk) begin
        if (we) begin
            row0[addr] <= wdata;
            row1[addr] <= row0[addr];
        end
    end

endmodule

// File: rtl/binary_window_filter.sv
// Streaming 3x3 binary mask filter (majority/erode/dilate/pass), 3-cycle latency.
// Ports: clk_in, rst_n_in, mode_in, thresh_in, data_in, hcount_in, vcount_in,
//        data_valid_in in; data_valid_out, hcount_out, vcount_out, pixel_out out.
module binary_window_filter
    import bwf_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int CHANNELS = 1,
    parameter int HW       = 11,
    parameter int VW       = 10
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [1:0]          mode_in,
    input  logic [3:0]          thresh_in,
    input  logic [CHANNELS-1:0] data_in,
    input  logic [HW-1:0]       hcount_in,
    input  logic [VW-1:0]       vcount_in,
    input  logic                data_valid_in,
    output logic                data_valid_out,
    output logic [HW-1:0]       hcount_out,
    output logic [VW-1:0]       vcount_out,
    output logic [CHANNELS-1:0] pixel_out
);

    localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    logic                take;
    logic [CHANNELS-1:0] lb_row1;
    logic [CHANNELS-1:0] lb_row2;
    logic [CHANNELS-1:0] tap_mid;
    logic [CHANNELS-1:0] tap_top;

    // Column index 0 = row v-2, 1 = row v-1, 2 = row v.
    logic [WIN-1:0][CHANNELS-1:0] new_col;
    logic [WIN-1:0][CHANNELS-1:0] col_l;
    logic [WIN-1:0][CHANNELS-1:0] col_c;
    logic [WIN-1:0][CHANNELS-1:0] col_r;

    logic                s1_valid;
    filt_mode_t          s1_mode;
    logic [3:0]          s1_thresh;
    logic [HW-1:0]       s1_h;
    logic [VW-1:0]       s1_v;

    logic [CHANNELS-1:0][WIN-1:0][1:0] row_cnt;
    logic [CHANNELS-1:0][WIN-1:0][1:0] s2_cnt;
    logic [CHANNELS-1:0] s2_ctr;
    logic                s2_valid;
    filt_mode_t          s2_mode;
    logic [3:0]          s2_thresh;
    logic [HW-1:0]       s2_h;
    logic [VW-1:0]       s2_v;

    logic [CHANNELS-1:0] decide;

    assign take = data_valid_in
                  && ({1'b0, hcount_in} < (HW+1)'(H_ACTIVE));

    bwf_line_buffer #(
        .DEPTH (H_ACTIVE),
        .W     (CHANNELS),
        .AW    (AW)
    ) u_lb (
        .clk    (clk_in),
        .we     (take),
        .addr   (hcount_in[AW-1:0]),
        .wdata  (data_in),
        .rdata0 (lb_row1),
        .rdata1 (lb_row2)
    );

    // Top padding comes from vcount, so stale buffer rows never leak.
    assign tap_mid = (vcount_in != '0)      ? lb_row1 : '0;
    assign tap_top = (vcount_in > VW'(1))   ? lb_row2 : '0;
    assign new_col = {data_in, tap_mid, tap_top};

    // S1: window shift, tag capture.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            col_l     <= '0;
            col_c     <= '0;
            col_r     <= '0;
            s1_valid  <= 1'b0;
            s1_mode   <= MAJ;
            s1_thresh <= '0;
            s1_h      <= '0;
            s1_v      <= '0;
        end else begin
            s1_valid <= take && (hcount_in != '0) && (vcount_in != '0);
            if (take) begin
                if (hcount_in == '0) begin
                    col_l <= '0;
                    col_c <= '0;
                end else begin
                    col_l <= col_c;
                    col_c <= col_r;
                end
                col_r     <= new_col;
                s1_mode   <= filt_mode_t'(mode_in);
                s1_thresh <= thresh_in;
                s1_h      <= hcount_in - HW'(1);
                s1_v      <= vcount_in - VW'(1);
            end
        end
    end

    always_comb begin
        row_cnt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < WIN; r++) begin
                row_cnt[c][r] = pop3({col_l[r][c], col_c[r][c], col_r[r][c]});
            end
        end
    end

    // S2: per-row popcounts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid  <= 1'b0;
            s2_cnt    <= '0;
            s2_ctr    <= '0;
            s2_mode   <= MAJ;
            s2_thresh <= '0;
            s2_h      <= '0;
            s2_v      <= '0;
        end else begin
            s2_valid  <= s1_valid;
            s2_cnt    <= row_cnt;
            s2_ctr    <= col_c[1];
            s2_mode   <= s1_mode;
            s2_thresh <= s1_thresh;
            s2_h      <= s1_h;
            s2_v      <= s1_v;
        end
    end

    always_comb begin : decide_blk
        logic [3:0] total;
        decide = '0;
        total  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            total = {2'b00, s2_cnt[c][0]}
                  + {2'b00, s2_cnt[c][1]}
                  + {2'b00, s2_cnt[c][2]};
            unique case (s2_mode)
                MAJ:    decide[c] = (total >= s2_thresh);
                ERODE:  decide[c] = (total == 4'd9);
                DILATE: decide[c] = (total != 4'd0);
                PASS:   decide[c] = s2_ctr[c];
            endcase
        end
    end

    // S3: registered outputs, held while no pixel is emitted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_valid_out <= 1'b0;
            pixel_out      <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
        end else begin
            data_valid_out <= s2_valid;
            if (s2_valid) begin
                pixel_out  <= decide;
                hcount_out <= s2_h;
                vcount_out <= s2_v;
            end
        end
    end

endmodule

// File: tb/tb_binary_window_filter.sv
// Self-checking bench for binary_window_filter: behavioural image model,
// per-cycle output compare, literal frame statistics and reset checks.
module tb_binary_window_filter;

    localparam int H  = 8;
    localparam int NV = 6;
    localparam int CH = 3;
    localparam int HW = 11;
    localparam int VW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode_in;
    logic [3:0]    thresh_in;
    logic [CH-1:0] data_in;
    logic [HW-1:0] hcount_in;
    logic [VW-1:0] vcount_in;
    logic          data_valid_in;
    logic          data_valid_out;
    logic [HW-1:0] hcount_out;
    logic [VW-1:0] vcount_out;
    logic [CH-1:0] pixel_out;

    binary_window_filter #(
        .H_ACTIVE (H),
        .CHANNELS (CH),
        .HW       (HW),
        .VW       (VW)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .mode_in        (mode_in),
        .thresh_in      (thresh_in),
        .data_in        (data_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .data_valid_in  (data_valid_in),
        .data_valid_out (data_valid_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .pixel_out      (pixel_out)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int            due;
        int            h;
        int            v;
        logic [CH-1:0] pix;
    } exp_t;

    exp_t eq[$];
    exp_t qa[$];
    exp_t qb[$];
    exp_t ce;
    int   rec_sel = 0;

    bit img [CH][16][16];
    bit rnd [CH][16][16];

    int vectors = 0;
    int fails = 0;
    int cyc = 0;

    int            last_h = 0;
    int            last_v = 0;
    logic [CH-1:0] last_pix = '0;

    int            n_out;
    int            ones [CH];
    int            int_ones [CH];
    int            first_h;
    int            first_v;
    int            first_cyc;
    logic [CH-1:0] first_pix;
    int            in11_cyc;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [CH-1:0] gen(int pat, int h, int v);
        logic [CH-1:0] d;
        case (pat)
            0:       d[0] = 1'b1;
            1:       d[0] = !(h == 4 && v == 3);
            2:       d[0] = (h == 4 && v == 3);
            3:       d[0] = rnd[0][v][h];
            default: d[0] = 1'b0;
        endcase
        d[1] = (((h + v) % 2) == 0);
        d[2] = rnd[2][v][h];
        return d;
    endfunction

    // Count ones in the 3x3 neighbourhood of centre (h-1,v-1),
    // pixels left of column 0 or above row 0 count as zero.
    function automatic logic [CH-1:0] model_px(int h, int v, int m, int t);
        logic [CH-1:0] r;
        int cnt;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            cnt = 0;
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    if (h - 1 + dx >= 0 && v - 1 + dy >= 0)
                        cnt += int'(img[c][v-1+dy][h-1+dx]);
                end
            end
            case (m)
                0:       r[c] = (cnt >= t);
                1:       r[c] = (cnt == 9);
                2:       r[c] = (cnt >= 1);
                default: r[c] = img[c][v-1][h-1];
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        while (eq.size() > 0 && eq[0].due < cyc) begin
            vectors++;
            fails++;
            $display("FAIL late_output: expected at cycle %0d, now %0d",
                     eq[0].due, cyc);
            void'(eq.pop_front());
        end
        if (eq.size() > 0 && eq[0].due == cyc) begin
            ce = eq.pop_front();
            check("valid_high", int'(data_valid_out), 1);
            if (data_valid_out) begin
                check("hcount", int'(hcount_out), ce.h);
                check("vcount", int'(vcount_out), ce.v);
                check("pixel", int'(pixel_out), int'(ce.pix));
                if (n_out == 0) begin
                    first_h   = int'(hcount_out);
                    first_v   = int'(vcount_out);
                    first_pix = pixel_out;
                    first_cyc = cyc;
                end
                n_out++;
                for (int c = 0; c < CH; c++) begin
                    ones[c] += int'(pixel_out[c]);
                    if (ce.h >= 1 && ce.v >= 1)
                        int_ones[c] += int'(pixel_out[c]);
                end
                if (rec_sel == 1) qa.push_back(ce);
                if (rec_sel == 2) qb.push_back(ce);
            end
            last_h   = ce.h;
            last_v   = ce.v;
            last_pix = ce.pix;
        end else begin
            check("valid_low", int'(data_valid_out), 0);
            check("hold_pixel", int'(pixel_out), int'(last_pix));
            check("hold_hcount", int'(hcount_out), last_h);
            check("hold_vcount", int'(vcount_out), last_v);
        end
    end

    task automatic clear_stats();
        n_out     = 0;
        first_h   = -1;
        first_v   = -1;
        first_cyc = -1;
        first_pix = '1;
        in11_cyc  = -1;
        for (int c = 0; c < CH; c++) begin
            ones[c]     = 0;
            int_ones[c] = 0;
        end
    endtask

    task automatic drive(int h, int v, logic [CH-1:0] d, int m, int t);
        @(negedge clk);
        data_valid_in = 1'b1;
        hcount_in     = HW'(h);
        vcount_in     = VW'(v);
        data_in       = d;
        mode_in       = 2'(m);
        thresh_in     = 4'(t);
        if (h < H) begin
            for (int c = 0; c < CH; c++) img[c][v][h] = d[c];
            if (h == 1 && v == 1) in11_cyc = cyc;
            if (h >= 1 && v >= 1)
                eq.push_back('{cyc + 3, h - 1, v - 1, model_px(h, v, m, t)});
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_valid_in = 1'b0;
            data_in       = CH'($urandom);
            hcount_in     = HW'($urandom_range(0, H - 1));
            vcount_in     = VW'($urandom_range(0, NV - 1));
        end
    endtask

    task automatic run_frame(int pat, int m, int t, bit gaps, bit rmode,
                             int stop_v = NV, int stop_h = 0);
        int mm;
        int tt;
        mm = m;
        tt = t;
        for (int v = 0; v < NV; v++) begin
            for (int h = 0; h < H; h++) begin
                if (v == stop_v && h == stop_h) return;
                if (rmode) begin
                    mm = int'($urandom_range(0, 3));
                    tt = int'($urandom_range(0, 15));
                end
                drive(h, v, gen(pat, h, v), mm, tt);
                if (gaps && ($urandom_range(0, 1) == 1))
                    idle(int'($urandom_range(1, 3)));
            end
            drive(H + int'($urandom_range(0, 2)), v, '1, mm, tt);
        end
        idle(6);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        data_valid_in = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(data_valid_out), 0);
        check("arst_pixel", int'(pixel_out), 0);
        check("arst_hcount", int'(hcount_out), 0);
        check("arst_vcount", int'(vcount_out), 0);
        eq.delete();
        last_h   = 0;
        last_v   = 0;
        last_pix = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum;
        data_valid_in = 1'b0;
        mode_in       = 2'd0;
        thresh_in     = 4'd0;
        data_in       = '0;
        hcount_in     = '0;
        vcount_in     = '0;
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    rnd[c][y][x] = bit'($urandom_range(0, 1));
        clear_stats();

        repeat (3) @(negedge clk);
        check("reset_valid", int'(data_valid_out), 0);
        check("reset_pixel", int'(pixel_out), 0);
        check("reset_hcount", int'(hcount_out), 0);
        check("reset_vcount", int'(vcount_out), 0);
        rst_n = 1'b1;

        clear_stats();
        run_frame(0, 0, 5, 1'b0, 1'b0);
        check("ones_count", n_out, 35);
        check("ones_first_h", first_h, 0);
        check("ones_first_v", first_v, 0);
        check("ones_first_pix0", int'(first_pix[0]), 0);
        check("ones_latency", first_cyc - in11_cyc, 3);
        check("ones_interior", int_ones[0], 24);

        clear_stats();
        run_frame(1, 1, 5, 1'b0, 1'b0);
        check("erode_count", n_out, 35);
        check("erode_interior", int_ones[0], 15);

        clear_stats();
        run_frame(2, 2, 5, 1'b0, 1'b0);
        check("dilate_ones", ones[0], 9);

        clear_stats();
        run_frame(3, 0, 5, 1'b0, 1'b0);
        check("checker_interior", int_ones[1], 12);

        clear_stats();
        run_frame(3, 0, 0, 1'b0, 1'b0);
        sum = ones[0] + ones[1] + ones[2];
        check("thresh0_ones", sum, 105);

        clear_stats();
        run_frame(3, 0, 10, 1'b0, 1'b0);
        sum = ones[0] + ones[1] + ones[2];
        check("thresh10_ones", sum, 0);

        clear_stats();
        run_frame(3, 3, 0, 1'b0, 1'b0);

        rec_sel = 1;
        run_frame(3, 0, 4, 1'b0, 1'b0);
        rec_sel = 2;
        run_frame(3, 0, 4, 1'b1, 1'b0);
        rec_sel = 0;
        check("gap_stream_len", qb.size(), qa.size());
        for (int i = 0; i < qa.size() && i < qb.size(); i++) begin
            check("gap_stream",
                  (qb[i].h << 8) | (qb[i].v << 4) | int'(qb[i].pix),
                  (qa[i].h << 8) | (qa[i].v << 4) | int'(qa[i].pix));
        end

        run_frame(3, 0, 0, 1'b1, 1'b1);

        run_frame(0, 2, 0, 1'b0, 1'b0, 3, 4);
        reset_pulse();
        clear_stats();
        run_frame(4, 0, 1, 1'b0, 1'b0);
        check("post_reset_count", n_out, 35);
        check("post_reset_ones0", ones[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
